// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake and end-of-word pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of each word.
module piso_shift_register #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(NBITS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [NBITS-1:0]   load_word;
  logic               last_c;
  logic               accept_c;

  // Word as placed in the shift register; the parity bit sits right behind the last data bit.
  always_comb begin
    load_word = '0;
`ifdef PISO_PARITY_EN
    if (LSB_FIRST != 0) begin
      load_word = {^parallel_in, parallel_in};
    end else begin
      load_word = {parallel_in, ^parallel_in};
    end
`else
    load_word = parallel_in;
`endif
  end

  assign last_c     = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(NBITS - 1));
  assign load_ready = reset_n && ((state_q == ST_IDLE) || last_c);
  assign accept_c   = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
      end
      ST_SHIFT: begin
        // Zero-fill keeps the head bit at 0 once the word has drained.
        if (LSB_FIRST != 0) begin
          shreg_d = {1'b0, shreg_q[NBITS-1:1]};
        end else begin
          shreg_d = {shreg_q[NBITS-2:0], 1'b0};
        end
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (last_c) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_c) begin
      shreg_d = load_word;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end
  end

  assign serial_out   = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[NBITS-1];
  assign serial_valid = (state_q == ST_SHIFT);
  assign busy         = (state_q == ST_SHIFT);
  assign done         = done_q;

endmodule
